ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.
//   Counterpart of the ps2_keyboard receiver; shares the ps2_clk/ps2_data lines through open-drain enables.
//   Sits beside ps2_keyboard under top; busy gates the receiver so it ignores host-driven frames.
// PARAMETERS
//   INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before start (100 us @ 50 MHz)
//   TIMEOUT_CYCLES  1000000  max clk cycles from clock release to ACK/idle before abort (20 ms @ 50 MHz)
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   rst         in   1  synchronous, active-high reset
//   tx_data     in   8  command byte, sampled when tx_valid && tx_ready
//   tx_valid    in   1  request to send tx_data
//   tx_ready    out  1  high only in IDLE
//   tx_done     out  1  1-cycle pulse: frame sent and acknowledged, bus idle again
//   tx_err      out  1  1-cycle pulse: timeout or bad ACK; frame abandoned
//   busy        out  1  high in every state except IDLE
//   ps2_clk     in   1  raw PS/2 clock line (async)
//   ps2_data    in   1  raw PS/2 data line (async)
//   ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release (pulled high)
//   ps2_data_oe out  1  1 = drive ps2_data low, 0 = release
// BEHAVIOUR
//   - Both PS/2 inputs pass through 3-FF synchronisers; fall = sync[2] & ~sync[1] on ps2_clk.
//   - Reset: tx_ready=1, tx_done=0, tx_err=0, busy=0, ps2_clk_oe=0, ps2_data_oe=0, state IDLE, counters 0.
//     Reset mid-frame releases both lines at that edge; no done/err pulse.
//   - Frame: 8 data bits LSB first, odd parity (parity = ~^tx_data), stop = released (1).
//   - FSM (all outputs registered):
//     IDLE:    accept on tx_valid&&tx_ready; latch byte+parity into 10-bit shreg; clk_oe=1 -> INHIBIT.
//     INHIBIT: hold clk_oe=1 for INHIBIT_CYCLES; last cycle sets data_oe=1 (start bit) -> RELEASE.
//     RELEASE: clk_oe=0, data_oe stays 1; start timeout counter -> SHIFT, bitcnt=0.
//     SHIFT:   on each fall: data_oe = ~shreg[0], shift, bitcnt++. Falls 1-8 data, 9 parity,
//              10 stop (data_oe=0). After fall 10 -> ACK.
//     ACK:     on fall 11 sample synced ps2_data: 0 -> WAIT_IDLE; 1 -> ERR.
//     WAIT_IDLE: wait until synced ps2_clk and ps2_data both 1 -> DONE.
//     DONE:    tx_done=1 for one cycle -> IDLE.  ERR: tx_err=1, oe both 0 for one cycle -> IDLE.
//   - Timeout: counter runs from RELEASE through WAIT_IDLE; reaching TIMEOUT_CYCLES-1 in any of those
//     states forces ERR (lines released next edge), regardless of other events in that cycle.
//   - Timeout wins over a simultaneous fall; ACK sampling uses only the synced value at the fall cycle.
//   - tx_valid while busy is ignored (not queued); tx_data changes after acceptance have no effect.
//   - Latency: first bus activity (clk_oe=1) one cycle after acceptance; tx_done 1 cycle after idle seen.
//   - Counters sized $clog2(TIMEOUT_CYCLES+1) / $clog2(INHIBIT_CYCLES+1); no wrap possible.
// CONFIGURATION
//   PS2_TX_ACK_CHECK_EN defined: ACK state checks the device ACK bit; ack=1 -> tx_err.
//   PS2_TX_ACK_CHECK_EN undefined: fall 11 taken as ACK without sampling data -> WAIT_IDLE;
//     tx_err only from timeout.
// TESTING  (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clock period 40 clk)
//   1 tx_data=0xED, valid 1 cycle -> clk_oe=1 for 8 cycles, bits 1,0,1,1,0,1,1,1 parity 1 stop 1, ack 0 -> one tx_done, no tx_err.
//   2 tx_data=0xF4 -> bits 0,0,1,0,1,1,1,1 parity 0; device sees byte 0xF4, tx_done pulse.
//   3 device drives ack=1 -> tx_err pulse (ACK_CHECK_EN) / tx_done (undefined); both oe=0 after.
//   4 device never clocks after release -> tx_err exactly 2000 cycles after RELEASE, oe both 0.
//   5 rst asserted at fall 5 -> next edge oe=0, tx_ready=1, no pulse; new 0xED frame then succeeds.
//   6 tx_valid held high with 0x00 during a 0xED frame -> ignored; byte 0x00 sent only after tx_done if still valid.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving the shared lines via open-drain enables.
// Define PS2_TX_ACK_CHECK_EN to abandon the frame when the device's ACK bit reads high.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;
    localparam logic [2:0] ERR       = 3'd7;

    logic [2:0]    state;
    logic [2:0]    clk_sync;
    logic [2:0]    data_sync;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          fall;
    logic          line_idle;
    logic          timed;
    logic          timeout;

    // Synchronisers reset to the idle-high line level so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign fall      = clk_sync[2] & ~clk_sync[1];
    assign line_idle = clk_sync[2] & data_sync[2];
    assign timed     = (state == RELEASE) || (state == SHIFT) ||
                       (state == ACK) || (state == WAIT_IDLE);
    assign timeout   = timed && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            shreg       <= '0;
            bitcnt      <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            // A stuck device is abandoned even if a clock edge arrives in the same cycle.
            if (timeout) begin
                state       <= ERR;
                tx_err      <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end else begin
                if (timed) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready) begin
                            shreg      <= {1'b1, ~^tx_data, tx_data};
                            inh_cnt    <= '0;
                            ps2_clk_oe <= 1'b1;
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        // Start bit goes low while the clock is still held, then the clock is freed.
                        if (inh_cnt == INH_LAST) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            to_cnt      <= '0;
                            state       <= RELEASE;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                            if (inh_cnt == INH_START) begin
                                ps2_data_oe <= 1'b1;
                            end
                        end
                    end
                    RELEASE: begin
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        if (fall) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b0, shreg[9:1]};
                            bitcnt      <= bitcnt + 1'b1;
                            if (bitcnt == 4'd9) begin
                                state <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            if (data_sync[2]) begin
                                state       <= ERR;
                                tx_err      <= 1'b1;
                                ps2_clk_oe  <= 1'b0;
                                ps2_data_oe <= 1'b0;
                            end else begin
                                state <= WAIT_IDLE;
                            end
`else
                            state <= WAIT_IDLE;
`endif
                        end
                    end
                    WAIT_IDLE: begin
                        if (line_idle) begin
                            tx_done <= 1'b1;
                            state   <= DONE;
                        end
                    end
                    DONE: begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                    ERR: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        tx_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;
    logic       clk_oe;
    logic       data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       bus_clk;
    logic       bus_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int inh_len = 0;
    int last_inh_len = 0;
    int rel_cyc = 0;
    int err_cyc = 0;

    assign bus_clk  = ~(clk_oe | dev_clk_low);
    assign bus_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(8),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .busy(busy),
        .ps2_clk(bus_clk),
        .ps2_data(bus_data),
        .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and clock-hold run length, observed mid-cycle.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (clk_oe === 1'b1) begin
            inh_len++;
        end else if (inh_len != 0) begin
            last_inh_len = inh_len;
            rel_cyc = cyc;
            inh_len = 0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit keep_valid);
        @(negedge clk);
        tx_data = data;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // Device side: waits for the start condition, clocks 10 bits in, then answers fall 11.
    // abort_at > 0 leaves the clock held low at that fall and returns early.
    task automatic deviceFrame(input logic ack_bit, input int abort_at,
                               output logic [9:0] bits, output bit ok);
        int t;
        ok = 1'b1;
        bits = '0;
        t = 0;
        while (!(bus_clk === 1'b1 && bus_data === 1'b0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            ok = 1'b0;
            return;
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            if (abort_at == i + 1) return;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
            bits[i] = bus_data;
            repeat (10) @(negedge clk);
        end
        dev_data_low = ~ack_bit;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic waitPulse(input int limit);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [9:0] bits;
        bit ok;
        int d0;
        int e0;
        int n;

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", tx_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_clk_oe", clk_oe, 0);
        checkOutput("rst_data_oe", data_oe, 0);
        checkOutput("rst_done", tx_done, 0);
        checkOutput("rst_err", tx_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED with good ACK
        d0 = done_cnt; e0 = err_cnt;
        applyStimulus(8'hED, 1'b0);
        checkOutput("t1_clk_oe_latency", clk_oe, 1);
        checkOutput("t1_ready_low", tx_ready, 0);
        checkOutput("t1_busy", busy, 1);
        deviceFrame(1'b0, 0, bits, ok);
        checkOutput("t1_dev_ok", ok, 1);
        checkOutput("t1_bits", bits, 10'h3ED);
        checkOutput("t1_inhibit_len", last_inh_len, 8);
        waitPulse(200);
        checkOutput("t1_done_cnt", done_cnt - d0, 1);
        checkOutput("t1_err_cnt", err_cnt - e0, 0);
        checkOutput("t1_ready_after", tx_ready, 1);
        checkOutput("t1_lines_free", {clk_oe, data_oe}, 0);

        // 0xF4 enable command
        d0 = done_cnt; e0 = err_cnt;
        applyStimulus(8'hF4, 1'b0);
        deviceFrame(1'b0, 0, bits, ok);
        checkOutput("t2_dev_ok", ok, 1);
        checkOutput("t2_bits", bits, 10'h2F4);
        waitPulse(200);
        checkOutput("t2_done_cnt", done_cnt - d0, 1);
        checkOutput("t2_err_cnt", err_cnt - e0, 0);

        // Device answers with ACK high
        d0 = done_cnt; e0 = err_cnt;
        applyStimulus(8'hED, 1'b0);
        deviceFrame(1'b1, 0, bits, ok);
        checkOutput("t3_bits", bits, 10'h3ED);
        waitPulse(200);
`ifdef PS2_TX_ACK_CHECK_EN
        checkOutput("t3_err_cnt", err_cnt - e0, 1);
        checkOutput("t3_done_cnt", done_cnt - d0, 0);
`else
        checkOutput("t3_err_cnt", err_cnt - e0, 0);
        checkOutput("t3_done_cnt", done_cnt - d0, 1);
`endif
        checkOutput("t3_lines_free", {clk_oe, data_oe}, 0);

        // Silent device: timeout
        d0 = done_cnt; e0 = err_cnt;
        applyStimulus(8'hF4, 1'b0);
        waitPulse(2200);
        checkOutput("t4_err_cnt", err_cnt - e0, 1);
        checkOutput("t4_done_cnt", done_cnt - d0, 0);
        checkOutput("t4_timeout_cycles", err_cyc - rel_cyc, 2000);
        checkOutput("t4_lines_free", {clk_oe, data_oe}, 0);
        checkOutput("t4_ready", tx_ready, 1);

        // Reset at fall 5, then a clean frame
        d0 = done_cnt; e0 = err_cnt;
        applyStimulus(8'hED, 1'b0);
        deviceFrame(1'b0, 5, bits, ok);
        checkOutput("t5_data_oe_before", data_oe, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_rst_lines_free", {clk_oe, data_oe}, 0);
        checkOutput("t5_rst_ready", tx_ready, 1);
        checkOutput("t5_rst_busy", busy, 0);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        applyStimulus(8'hED, 1'b0);
        deviceFrame(1'b0, 0, bits, ok);
        checkOutput("t5_bits", bits, 10'h3ED);
        waitPulse(200);
        checkOutput("t5_done_cnt", done_cnt - d0, 1);

        // tx_valid held with 0x00 during a 0xED frame
        d0 = done_cnt; e0 = err_cnt;
        applyStimulus(8'hED, 1'b1);
        tx_data = 8'h00;
        deviceFrame(1'b0, 0, bits, ok);
        checkOutput("t6_first_bits", bits, 10'h3ED);
        waitPulse(200);
        checkOutput("t6_first_done", done_cnt - d0, 1);
        n = 0;
        while (tx_ready !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        checkOutput("t6_reaccept", tx_ready, 0);
        deviceFrame(1'b0, 0, bits, ok);
        checkOutput("t6_second_bits", bits, 10'h300);
        waitPulse(200);
        checkOutput("t6_second_done", done_cnt - d0, 2);
        checkOutput("t6_err_cnt", err_cnt - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
